i2cmb_wb_sequencer: RTL and testbench

- Synthesizable Wishbone master that turns high-level I2C transaction requests into the IICMB register-access sequence (CSR/DPR/CMDR) and checks the response status.
- Supports multi-bus selection, variable-length read and write bursts, timeouts and error reporting.
- Sits between an internal request source and the `iicmb_m_wb` slave port, replacing hand-written bench register pokes with a reusable front end.

---
 rtl/i2cmb_wb_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_i2cmb_wb_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2cmb_wb_sequencer.sv
// rtl/i2cmb_wb_sequencer.sv - Wishbone master sequencing IICMB register accesses for I2C transactions
// Every register access is a registered Wishbone cycle; WAIT polls irq then reads CMDR for status.
module i2cmb_wb_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int NUM_I2C_BUSSES = 1,
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int BUS_W = (NUM_I2C_BUSSES > 1) ? $clog2(NUM_I2C_BUSSES) : 1,
    localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [BUS_W-1:0]         req_bus_i,
    input  logic [6:0]               req_addr_i,
    input  logic                     req_rw_i,
    input  logic [LEN_W-1:0]         req_len_i,
    input  logic                     wdata_valid_i,
    input  logic [7:0]               wdata_i,
    output logic                     wdata_ready_o,
    output logic                     rdata_valid_o,
    output logic [7:0]               rdata_o,
    output logic                     done_o,
    output logic [2:0]               status_o,
    output logic                     busy_o,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CSR = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] A_DPR = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CMD = WB_ADDR_WIDTH'(2);
    localparam logic [2:0] ST_OK = 3'd0, ST_NAK = 3'd1, ST_AL = 3'd2, ST_ERR = 3'd3,
                           ST_TO = 3'd4, ST_BAD = 3'd5;

    typedef enum logic [4:0] {
        S_INIT, S_IDLE, S_BADBUS, S_SB_DPR, S_SB_CMD, S_START, S_AD_DPR, S_AD_CMD,
        S_WR_WAIT, S_WR_DPR, S_WR_CMD, S_RD_CMD, S_RD_DPR, S_STOP, S_WAIT, S_STAT,
        S_TO_OFF, S_TO_ON
    } state_t;

    state_t state, state_n, ret_state, ret_n;
    logic [BUS_W-1:0] bus, last_bus;
    logic             last_valid;
    logic [6:0]       addr;
    logic             rw;
    logic [LEN_W-1:0] cnt;
    logic [7:0]       wbyte;
    logic [2:0]       pend, pend_n, stat_n;
    logic [TO_W-1:0]  tcount;

    logic                     acc_go, acc_we, wb_ack;
    logic [WB_ADDR_WIDTH-1:0] acc_adr;
    logic [WB_DATA_WIDTH-1:0] acc_dat;
    logic done_n, accept, set_last, inval, rd_pulse, wtake;

    assign wb_ack        = cyc_o && ack_i;
    assign wdata_ready_o = (state == S_WR_WAIT);

    always_comb begin
        state_n  = state;
        ret_n    = ret_state;
        pend_n   = pend;
        stat_n   = status_o;
        acc_go   = 1'b0;
        acc_we   = 1'b1;
        acc_adr  = A_CMD;
        acc_dat  = '0;
        done_n   = 1'b0;
        accept   = 1'b0;
        set_last = 1'b0;
        inval    = 1'b0;
        rd_pulse = 1'b0;
        wtake    = 1'b0;
        case (state)
            S_INIT: begin
                acc_go = !cyc_o; acc_adr = A_CSR; acc_dat = 8'hC0;
                if (wb_ack) state_n = S_IDLE;
            end
            S_IDLE: if (req_valid_i && req_ready_o) begin
                accept = 1'b1;
                if (32'(req_bus_i) >= NUM_I2C_BUSSES)            state_n = S_BADBUS;
                else if (!last_valid || last_bus != req_bus_i)    state_n = S_SB_DPR;
                else                                              state_n = S_START;
            end
            S_BADBUS: begin
                done_n = 1'b1; stat_n = ST_BAD; state_n = S_IDLE;
            end
            S_SB_DPR: begin
                acc_go = !cyc_o; acc_adr = A_DPR; acc_dat = 8'(bus);
                if (wb_ack) state_n = S_SB_CMD;
            end
            S_SB_CMD: begin
                acc_go = !cyc_o; acc_dat = 8'h06;
                if (wb_ack) begin state_n = S_WAIT; ret_n = S_START; end
            end
            S_START: begin
                acc_go = !cyc_o; acc_dat = 8'h04;
                if (wb_ack) begin state_n = S_WAIT; ret_n = S_AD_DPR; end
            end
            S_AD_DPR: begin
                acc_go = !cyc_o; acc_adr = A_DPR; acc_dat = {addr, rw};
                if (wb_ack) state_n = S_AD_CMD;
            end
            S_AD_CMD: begin
                acc_go = !cyc_o; acc_dat = 8'h01;
                if (wb_ack) begin
                    state_n = S_WAIT;
                    ret_n   = (cnt == '0) ? S_STOP : (rw ? S_RD_CMD : S_WR_WAIT);
                end
            end
            S_WR_WAIT: if (wdata_valid_i) begin
                wtake = 1'b1; state_n = S_WR_DPR;
            end
            S_WR_DPR: begin
                acc_go = !cyc_o; acc_adr = A_DPR; acc_dat = wbyte;
                if (wb_ack) state_n = S_WR_CMD;
            end
            S_WR_CMD: begin
                acc_go = !cyc_o; acc_dat = 8'h01;
                if (wb_ack) begin state_n = S_WAIT; ret_n = (cnt == '0) ? S_STOP : S_WR_WAIT; end
            end
            S_RD_CMD: begin
                acc_go = !cyc_o; acc_dat = (cnt == LEN_W'(1)) ? 8'h03 : 8'h02;
                if (wb_ack) begin state_n = S_WAIT; ret_n = S_RD_DPR; end
            end
            S_RD_DPR: begin
                acc_go = !cyc_o; acc_we = 1'b0; acc_adr = A_DPR;
                if (wb_ack) begin
                    rd_pulse = 1'b1;
                    state_n  = (cnt == LEN_W'(1)) ? S_STOP : S_RD_CMD;
                end
            end
            S_STOP: begin
                acc_go = !cyc_o; acc_dat = 8'h05;
                if (wb_ack) begin state_n = S_WAIT; ret_n = S_IDLE; end
            end
            S_WAIT: begin
                if (irq_i)                                        state_n = S_STAT;
                else if (tcount == TO_W'(TIMEOUT_CYCLES - 1))     state_n = S_TO_OFF;
            end
            S_STAT: begin
                acc_go = !cyc_o; acc_we = 1'b0;
                if (wb_ack) begin
                    // ret_state == S_IDLE marks the STOP wait; completing it ends the transaction
                    if (dat_i[5]) begin
                        done_n = 1'b1; stat_n = ST_AL; inval = 1'b1; state_n = S_IDLE;
                    end else if (dat_i[4]) begin
                        done_n = 1'b1; stat_n = ST_ERR; inval = 1'b1; state_n = S_IDLE;
                    end else if (dat_i[6]) begin
                        if (ret_state == S_IDLE) begin
                            done_n = 1'b1; stat_n = ST_NAK; state_n = S_IDLE;
                        end else begin
                            pend_n = ST_NAK; state_n = S_STOP;
                        end
                    end else if (dat_i[7]) begin
                        if (ret_state == S_IDLE) begin
                            done_n = 1'b1; stat_n = pend; state_n = S_IDLE;
                        end else begin
                            set_last = (ret_state == S_START);
                            state_n  = ret_state;
                        end
                    end else begin
                        state_n = S_WAIT;
                    end
                end
            end
            S_TO_OFF: begin
                acc_go = !cyc_o; acc_adr = A_CSR; acc_dat = 8'h00;
                if (wb_ack) state_n = S_TO_ON;
            end
            S_TO_ON: begin
                acc_go = !cyc_o; acc_adr = A_CSR; acc_dat = 8'hC0;
                if (wb_ack) begin
                    done_n = 1'b1; stat_n = ST_TO; inval = 1'b1; state_n = S_IDLE;
                end
            end
            default: state_n = S_INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_INIT;  ret_state <= S_INIT;
            cyc_o <= 1'b0;    stb_o <= 1'b0;  we_o <= 1'b0;
            adr_o <= '0;      dat_o <= '0;
            bus <= '0;  addr <= '0;  rw <= 1'b0;  cnt <= '0;  wbyte <= '0;
            pend <= ST_OK;    tcount <= '0;
            last_bus <= '0;   last_valid <= 1'b0;
            rdata_o <= '0;    rdata_valid_o <= 1'b0;
            done_o <= 1'b0;   status_o <= ST_OK;
            busy_o <= 1'b0;   req_ready_o <= 1'b0;
        end else begin
            state     <= state_n;
            ret_state <= ret_n;
            pend      <= accept ? ST_OK : pend_n;
            if (acc_go) begin
                cyc_o <= 1'b1; stb_o <= 1'b1; we_o <= acc_we;
                adr_o <= acc_adr; dat_o <= acc_dat;
            end else if (wb_ack) begin
                cyc_o <= 1'b0; stb_o <= 1'b0; we_o <= 1'b0;
            end
            rdata_valid_o <= rd_pulse;
            if (rd_pulse) rdata_o <= dat_i;
            if (accept) begin
                bus  <= req_bus_i;
                addr <= req_addr_i;
                rw   <= req_rw_i;
                cnt  <= (req_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req_len_i;
            end else if ((wtake || rd_pulse) && cnt != '0) begin
                cnt <= cnt - LEN_W'(1);
            end
            if (wtake) wbyte <= wdata_i;
            tcount <= (state == S_WAIT) ? tcount + TO_W'(1) : '0;
            if (inval) last_valid <= 1'b0;
            else if (set_last) begin
                last_bus   <= bus;
                last_valid <= 1'b1;
            end
            done_o      <= done_n;
            status_o    <= stat_n;
            busy_o      <= (state_n != S_INIT) && (state_n != S_IDLE);
            req_ready_o <= (state_n == S_IDLE);
        end
    end
endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// tb/tb_i2cmb_wb_sequencer.sv - scoreboard bench for i2cmb_wb_sequencer with an IICMB slave model
module tb_i2cmb_wb_sequencer;
    localparam int BUS_W = 2;
    localparam int LEN_W = 5;

    logic clk = 1'b0;
    logic rst;
    logic req_valid, req_ready, req_rw;
    logic [BUS_W-1:0] req_bus;
    logic [6:0] req_addr;
    logic [LEN_W-1:0] req_len;
    logic wdata_valid, wdata_ready, rdata_valid, done, busy;
    logic [7:0] wdata, rdata;
    logic [2:0] status;
    logic cyc, stb, we, ack, irq;
    logic [1:0] adr;
    logic [7:0] dat_w, dat_r;

    i2cmb_wb_sequencer #(
        .WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .NUM_I2C_BUSSES(3),
        .MAX_LEN(16), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_bus_i(req_bus),
        .req_addr_i(req_addr), .req_rw_i(req_rw), .req_len_i(req_len),
        .wdata_valid_i(wdata_valid), .wdata_i(wdata), .wdata_ready_o(wdata_ready),
        .rdata_valid_o(rdata_valid), .rdata_o(rdata),
        .done_o(done), .status_o(status), .busy_o(busy),
        .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_w),
        .dat_i(dat_r), .ack_i(ack), .irq_i(irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [10:0] exp_wb[$];
    logic [7:0]  exp_rd[$];
    logic [2:0]  exp_done[$];
    logic [7:0]  wq[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  last_dpr, cmdr_resp;
    int          irq_cnt;
    bit          irq_en = 1'b1;
    bit          cyc_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        exp_wb.push_back({1'b1, a, d});
    endtask

    task automatic rd(input logic [1:0] a);
        exp_wb.push_back({1'b0, a, 8'h00});
    endtask

    // IICMB slave: one-cycle registered ack, irq a few cycles after each command
    always @(posedge clk) begin
        if (rst) begin
            ack <= 1'b0; irq <= 1'b0; dat_r <= 8'h00; irq_cnt <= 0;
            last_dpr <= 8'h00; cmdr_resp <= 8'h80;
        end else begin
            ack <= 1'b0;
            if (irq_cnt != 0) begin
                irq_cnt <= irq_cnt - 1;
                if (irq_cnt == 1 && irq_en) irq <= 1'b1;
            end
            if (cyc && stb && !ack) begin
                ack <= 1'b1;
                if (we) begin
                    if (adr == 2'd1) last_dpr <= dat_w;
                    if (adr == 2'd2) begin
                        irq_cnt   <= 3;
                        cmdr_resp <= (dat_w == 8'h01 && last_dpr == 8'hFE) ? 8'h40 : 8'h80;
                    end
                end else if (adr == 2'd2) begin
                    dat_r <= cmdr_resp;
                    irq   <= 1'b0;
                end else if (adr == 2'd1) begin
                    dat_r <= (rd_q.size() != 0) ? rd_q.pop_front() : 8'h00;
                end
            end
        end
    end

    // Write-data stream source
    initial begin
        bit hs;
        wdata_valid = 1'b0;
        wdata = 8'h00;
        forever begin
            @(negedge clk);
            wdata_valid = (wq.size() != 0);
            wdata = wdata_valid ? wq[0] : 8'h00;
            hs = wdata_valid && wdata_ready;
            @(posedge clk);
            if (hs) void'(wq.pop_front());
        end
    end

    // Monitor: compares every DUT output event against the scoreboard queues
    always @(negedge clk) begin
        if (!rst) begin
            if (cyc && stb && ack) begin
                cyc_seen = 1'b1;
                if (exp_wb.size() == 0) check("wb_unexpected", {21'd0, we, adr, dat_w}, 32'hFFFF_FFFF);
                else check("wb_access", {21'd0, we, adr, we ? dat_w : 8'h00}, {21'd0, exp_wb.pop_front()});
            end
            if (rdata_valid) begin
                if (exp_rd.size() == 0) check("rdata_unexpected", {24'd0, rdata}, 32'hFFFF_FFFF);
                else check("rdata", {24'd0, rdata}, {24'd0, exp_rd.pop_front()});
            end
            if (done) begin
                check("done_ready", {31'd0, req_ready}, 32'd1);
                if (exp_done.size() == 0) check("done_unexpected", {29'd0, status}, 32'hFFFF_FFFF);
                else check("status", {29'd0, status}, {29'd0, exp_done.pop_front()});
            end
        end
    end

    task automatic do_req(input logic [BUS_W-1:0] b, input logic [6:0] a, input logic r,
                          input logic [LEN_W-1:0] l);
        int k;
        @(negedge clk);
        req_valid = 1'b1; req_bus = b; req_addr = a; req_rw = r; req_len = l;
        k = 0;
        while (!req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 3000);
        if (!done) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; req_bus = '0; req_addr = '0; req_rw = 1'b0; req_len = '0;
        cyc_seen = 1'b0;
        #50;
        check("reset_cyc", {31'd0, cyc}, 32'd0);
        check("reset_ready", {31'd0, req_ready}, 32'd0);
        check("reset_busy_done", {30'd0, busy, done}, 32'd0);
        check("reset_status", {29'd0, status}, 32'd0);
        wr(2'd0, 8'hC0);
        #63 rst = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("init_ready", {31'd0, req_ready}, 32'd1);
        check("init_drained", exp_wb.size(), 32'd0);

        // write bus 1, addr 0x22, bytes 0x05 0x0A
        wr(2'd1, 8'h01); wr(2'd2, 8'h06); rd(2'd2);
        wr(2'd2, 8'h04); rd(2'd2);
        wr(2'd1, 8'h44); wr(2'd2, 8'h01); rd(2'd2);
        wr(2'd1, 8'h05); wr(2'd2, 8'h01); rd(2'd2);
        wr(2'd1, 8'h0A); wr(2'd2, 8'h01); rd(2'd2);
        wr(2'd2, 8'h05); rd(2'd2);
        exp_done.push_back(3'd0);
        wq.push_back(8'h05); wq.push_back(8'h0A);
        do_req(2'd1, 7'h22, 1'b0, 5'd2);
        wait_done(n);
        check("write_drained", exp_wb.size(), 32'd0);

        // read 3 bytes from same bus: no SET_BUS
        rd_q.push_back(8'h64); rd_q.push_back(8'h65); rd_q.push_back(8'h66);
        wr(2'd2, 8'h04); rd(2'd2);
        wr(2'd1, 8'h45); wr(2'd2, 8'h01); rd(2'd2);
        for (int i = 0; i < 3; i++) begin
            wr(2'd2, (i == 2) ? 8'h03 : 8'h02); rd(2'd2); rd(2'd1);
            exp_rd.push_back(8'(8'h64 + i));
        end
        wr(2'd2, 8'h05); rd(2'd2);
        exp_done.push_back(3'd0);
        do_req(2'd1, 7'h22, 1'b1, 5'd3);
        wait_done(n);
        check("read_drained", exp_wb.size() + exp_rd.size(), 32'd0);

        // no slave at 0x7F: NAK, STOP still issued
        wr(2'd2, 8'h04); rd(2'd2);
        wr(2'd1, 8'hFE); wr(2'd2, 8'h01); rd(2'd2);
        wr(2'd2, 8'h05); rd(2'd2);
        exp_done.push_back(3'd1);
        do_req(2'd1, 7'h7F, 1'b0, 5'd1);
        wait_done(n);
        check("nak_drained", exp_wb.size(), 32'd0);

        // bus out of range
        cyc_seen = 1'b0;
        exp_done.push_back(3'd5);
        do_req(2'd3, 7'h22, 1'b0, 5'd1);
        wait_done(n);
        check("badbus_latency", {31'd0, (n <= 2)}, 32'd1);
        check("badbus_no_cyc", {31'd0, cyc_seen}, 32'd0);

        // irq never arrives: controller reset and TIMEOUT
        irq_en = 1'b0;
        wr(2'd2, 8'h04); wr(2'd0, 8'h00); wr(2'd0, 8'hC0);
        exp_done.push_back(3'd4);
        do_req(2'd1, 7'h22, 1'b0, 5'd1);
        wait_done(n);
        check("timeout_drained", exp_wb.size(), 32'd0);
        irq_en = 1'b1;

        // address-only probe on same bus must re-select it after the timeout
        wr(2'd1, 8'h01); wr(2'd2, 8'h06); rd(2'd2);
        wr(2'd2, 8'h04); rd(2'd2);
        wr(2'd1, 8'h44); wr(2'd2, 8'h01); rd(2'd2);
        wr(2'd2, 8'h05); rd(2'd2);
        exp_done.push_back(3'd0);
        do_req(2'd1, 7'h22, 1'b0, 5'd0);
        wait_done(n);
        check("probe_drained", exp_wb.size(), 32'd0);

        // length 20 is clamped to 16 bytes
        wr(2'd2, 8'h04); rd(2'd2);
        wr(2'd1, 8'h21); wr(2'd2, 8'h01); rd(2'd2);
        for (int i = 0; i < 16; i++) begin
            rd_q.push_back(8'(8'hA0 + i));
            wr(2'd2, (i == 15) ? 8'h03 : 8'h02); rd(2'd2); rd(2'd1);
            exp_rd.push_back(8'(8'hA0 + i));
        end
        wr(2'd2, 8'h05); rd(2'd2);
        exp_done.push_back(3'd0);
        do_req(2'd1, 7'h10, 1'b1, 5'd20);
        wait_done(n);
        check("clamp_drained", exp_wb.size() + exp_rd.size(), 32'd0);
        check("all_done_seen", exp_done.size(), 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
